text_cursor_ctrl: RTL
=====================

TEXT_CURSOR_CTRL -- requirements
Module: text_cursor_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 32, number of text columns (power of two).
REQ-002 SHALL have parameter ROWS, default 4, number of text rows (power of two).
REQ-003 SHALL have port clk  input  1  system clock (100 MHz); all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 SHALL have port wr_en  output  1  text-RAM write strobe.
REQ-008 SHALL have port wr_row  output  log2(ROWS)  text-RAM write row.
REQ-009 SHALL have port wr_col  output  log2(COLS)  text-RAM write column.
REQ-010 SHALL have port wr_data  output  8  text-RAM write byte.
REQ-011 SHALL have port cur_row  output  log2(ROWS)  cursor row, for display and debug.
REQ-012 SHALL have port cur_col  output  log2(COLS)  cursor column, for display and debug.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE or the pending register is full.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse when a byte is dropped.

Function
REQ-015 SHALL implement the states IDLE, CLR_SCREEN and CLR_LINE.
REQ-016 SHALL hold one pending byte register with a valid flag.
REQ-017 In IDLE with pending valid, SHALL process the pending byte; an rx_valid in the same cycle SHALL be loaded into pending.
REQ-018 In IDLE with pending empty, SHALL process rx_data when rx_valid is high.
REQ-019 Outside IDLE, SHALL load rx_valid into pending if pending is empty; otherwise SHALL drop the byte and pulse overflow for exactly one cycle.
REQ-020 Processing a printable byte (0x20..0x7E) in cycle N SHALL produce wr_en=1, wr_row=cur_row, wr_col=cur_col, wr_data=byte in cycle N+1, with the cursor advanced in N+1.
REQ-021 Cursor advance: col+1; at col=COLS-1 it SHALL set col=0 and row=(row+1) mod ROWS, then enter CLR_LINE on the new row.
REQ-022 0x0A (LF) SHALL set col=0 and row=(row+1) mod ROWS, then enter CLR_LINE on the new row, with no character write.
REQ-023 0x0D (CR) SHALL set col=0, with no write and no row change.
REQ-024 0x08 (BS): if col>0, SHALL set col-1; if col=0 and row>0, SHALL set row-1 and col=COLS-1; in both cases SHALL write 0x20 at the new position in N+1.
REQ-025 0x08 (BS) at (0,0) SHALL take no action.
REQ-026 0x0C (FF) SHALL enter CLR_SCREEN and home the cursor to (0,0).
REQ-027 Any other byte value SHALL be ignored: no write, no cursor change.
REQ-028 CLR_LINE SHALL write 0x20 to columns 0..COLS-1 of the cursor row, one per cycle, wr_en high for COLS consecutive cycles, then return to IDLE.
REQ-029 CLR_SCREEN SHALL write 0x20 to all ROWS*COLS cells in row-major order, wr_en high for ROWS*COLS consecutive cycles, then return to IDLE.
REQ-030 Row and column arithmetic SHALL wrap modulo ROWS and COLS; there SHALL be no scrolling.
REQ-031 wr_row, wr_col and wr_data SHALL hold their last values when wr_en=0.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 On reset, SHALL set cursor=(0,0), pending empty, wr_en=0, overflow=0, wr_row=0, wr_col=0, wr_data=0x20, and state=CLR_SCREEN in the cycle after reset is released.
REQ-034 Reset asserted mid-clear or mid-write SHALL abort the operation and restart per REQ-033.
REQ-035 Bytes arriving while reset is high SHALL be discarded.

Verification
REQ-036 Reset -> 128 consecutive wr_en cycles writing 0x20 at (0,0)..(3,31) row-major; busy then falls; cursor=(0,0).
REQ-037 In IDLE, send 'A' (0x41) at cycle N -> in cycle N+1: wr_en=1, (0,0), 0x41; cursor=(0,1).
REQ-038 Send 32 printable bytes -> the last one is written at (0,31), then 32 space writes on row 1; cursor=(1,0).
REQ-039 Send 0x0A then 'B' and 'C' one cycle apart during CLR_LINE -> 'B' is held in pending and 'C' is dropped with an overflow pulse; after the clear, 'B' is written at (1,0).
REQ-040 Cursor (2,0), send 0x08 -> 0x20 written at (1,31); cursor=(1,31). Send 0x08 at (0,0) -> no write.
REQ-041 Assert reset mid-CLR_SCREEN at cell 50 -> sweep restarts from (0,0) after reset is released; no stale pending byte is processed.

Source files
------------

// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl
// Turns a stream of received UART bytes into text-RAM writes for a
// COLS x ROWS character display. It tracks the cursor, interprets LF, CR, BS
// and FF, and sweeps spaces over a line or over the whole screen when needed.
// One byte can wait in a pending register while a clear sweep is running; a
// byte that arrives while the pending register is already full is dropped and
// flagged on overflow.
module text_cursor_ctrl #(
    parameter int COLS = 32,
    parameter int ROWS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    wr_en,
    output logic [$clog2(ROWS)-1:0] wr_row,
    output logic [$clog2(COLS)-1:0] wr_col,
    output logic [7:0]              wr_data,
    output logic [$clog2(ROWS)-1:0] cur_row,
    output logic [$clog2(COLS)-1:0] cur_col,
    output logic                    busy,
    output logic                    overflow
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] CLR_SCREEN = 2'd1;
    localparam logic [1:0] CLR_LINE   = 2'd2;

    logic [1:0]    state_q,     state_d;
    logic [RW-1:0] curRow_q,    curRow_d;
    logic [CW-1:0] curCol_q,    curCol_d;
    logic [RW-1:0] clrRow_q,    clrRow_d;
    logic [CW-1:0] clrCol_q,    clrCol_d;
    logic          pendValid_q, pendValid_d;
    logic [7:0]    pendData_q,  pendData_d;
    logic          wrEn_q,      wrEn_d;
    logic [RW-1:0] wrRow_q,     wrRow_d;
    logic [CW-1:0] wrCol_q,     wrCol_d;
    logic [7:0]    wrData_q,    wrData_d;
    logic          busy_q,      busy_d;
    logic          overflow_q,  overflow_d;

    logic          procValid;
    logic [7:0]    procByte;

    // Next-state logic: byte intake and pending buffering, clear sweeps, and
    // interpretation of the byte chosen for processing while idle.
    always_comb begin
        state_d     = state_q;
        curRow_d    = curRow_q;
        curCol_d    = curCol_q;
        clrRow_d    = clrRow_q;
        clrCol_d    = clrCol_q;
        pendValid_d = pendValid_q;
        pendData_d  = pendData_q;
        wrEn_d      = 1'b0;
        wrRow_d     = wrRow_q;
        wrCol_d     = wrCol_q;
        wrData_d    = wrData_q;
        overflow_d  = 1'b0;
        procValid   = 1'b0;
        procByte    = rx_data;

        case (state_q)
            IDLE: begin
                // Sweep counters sit at zero so every clear starts at column 0.
                clrRow_d = '0;
                clrCol_d = '0;
                if (pendValid_q) begin
                    // The buffered byte is older, so it goes first; a new byte
                    // arriving now simply takes its place in the buffer.
                    procValid   = 1'b1;
                    procByte    = pendData_q;
                    pendValid_d = rx_valid;
                    if (rx_valid) begin
                        pendData_d = rx_data;
                    end
                end else if (rx_valid) begin
                    procValid = 1'b1;
                end
            end

            CLR_LINE: begin
                wrEn_d   = 1'b1;
                wrRow_d  = curRow_q;
                wrCol_d  = clrCol_q;
                wrData_d = CH_SPACE;
                clrCol_d = clrCol_q + 1'b1;
                if (clrCol_q == COL_MAX) begin
                    state_d = IDLE;
                end
            end

            CLR_SCREEN: begin
                wrEn_d   = 1'b1;
                wrRow_d  = clrRow_q;
                wrCol_d  = clrCol_q;
                wrData_d = CH_SPACE;
                clrCol_d = clrCol_q + 1'b1;
                if (clrCol_q == COL_MAX) begin
                    clrRow_d = clrRow_q + 1'b1;
                    if (clrRow_q == ROW_MAX) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                // An unreachable encoding recovers by wiping the screen.
                state_d  = CLR_SCREEN;
                clrRow_d = '0;
                clrCol_d = '0;
            end
        endcase

        // While a sweep runs, one byte may wait; anything beyond that is lost.
        if ((state_q != IDLE) && rx_valid) begin
            if (!pendValid_q) begin
                pendValid_d = 1'b1;
                pendData_d  = rx_data;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (procValid) begin
            if ((procByte >= CH_SPACE) && (procByte <= CH_TILDE)) begin
                // Printable: write at the cursor, then advance it.
                wrEn_d   = 1'b1;
                wrRow_d  = curRow_q;
                wrCol_d  = curCol_q;
                wrData_d = procByte;
                if (curCol_q == COL_MAX) begin
                    curCol_d = '0;
                    curRow_d = curRow_q + 1'b1;
                    state_d  = CLR_LINE;
                end else begin
                    curCol_d = curCol_q + 1'b1;
                end
            end else if (procByte == CH_LF) begin
                curCol_d = '0;
                curRow_d = curRow_q + 1'b1;
                state_d  = CLR_LINE;
            end else if (procByte == CH_CR) begin
                curCol_d = '0;
            end else if (procByte == CH_BS) begin
                // Backspace erases the cell it steps back onto; at the home
                // position there is nowhere to go, so nothing happens.
                if (curCol_q != '0) begin
                    curCol_d = curCol_q - 1'b1;
                    wrEn_d   = 1'b1;
                    wrRow_d  = curRow_q;
                    wrCol_d  = curCol_q - 1'b1;
                    wrData_d = CH_SPACE;
                end else if (curRow_q != '0) begin
                    curRow_d = curRow_q - 1'b1;
                    curCol_d = COL_MAX;
                    wrEn_d   = 1'b1;
                    wrRow_d  = curRow_q - 1'b1;
                    wrCol_d  = COL_MAX;
                    wrData_d = CH_SPACE;
                end
            end else if (procByte == CH_FF) begin
                curRow_d = '0;
                curCol_d = '0;
                state_d  = CLR_SCREEN;
            end
        end

        // busy is derived from next-state values so the registered flag lines
        // up with the state and pending registers it describes.
        busy_d = (state_d != IDLE) || pendValid_d;
    end

    // State and output registers; reset restarts with a full-screen wipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLR_SCREEN;
            curRow_q    <= '0;
            curCol_q    <= '0;
            clrRow_q    <= '0;
            clrCol_q    <= '0;
            pendValid_q <= 1'b0;
            pendData_q  <= 8'h00;
            wrEn_q      <= 1'b0;
            wrRow_q     <= '0;
            wrCol_q     <= '0;
            wrData_q    <= CH_SPACE;
            busy_q      <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            curRow_q    <= curRow_d;
            curCol_q    <= curCol_d;
            clrRow_q    <= clrRow_d;
            clrCol_q    <= clrCol_d;
            pendValid_q <= pendValid_d;
            pendData_q  <= pendData_d;
            wrEn_q      <= wrEn_d;
            wrRow_q     <= wrRow_d;
            wrCol_q     <= wrCol_d;
            wrData_q    <= wrData_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wr_en    = wrEn_q;
    assign wr_row   = wrRow_q;
    assign wr_col   = wrCol_q;
    assign wr_data  = wrData_q;
    assign cur_row  = curRow_q;
    assign cur_col  = curCol_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
